cordic_top: RTL and testbench

Streaming fixed-point CORDIC sine/cosine engine. Angles are written into an input FIFO, processed by a 16-iteration rotation-mode pipeline, and the cos/sin result pairs are queued in a show-ahead output FIFO. The block sits between an angle producer and a result consumer, both using FIFO-style handshakes.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/fifo.sv | 39 +++
 rtl/cordic_top.sv | 77 +++++++
 tb/tb_cordic_top.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: Q14 constants, arctangent table and angle normalization shared by the CORDIC engine.
package cordic_pkg;
  localparam int CORDIC_ITER = 16;
  localparam int DATA_W = 16;
  localparam int ANGLE_W = 32;
  localparam int K_Q14 = 9949;
  localparam int PI_Q14 = 51471;
  localparam int HALF_PI_Q14 = 25735;
  localparam int TWO_PI_Q14 = 102943;
  localparam int ATAN_Q14 [0:15] = '{12867, 7596, 4013, 2037, 1022, 511, 255, 127,
                                     63, 31, 15, 7, 3, 1, 0, 0};
  typedef struct packed {
    logic neg;
    logic [ANGLE_W-1:0] z;
  } norm_t;
  // Fold into -pi..pi, then into -pi/2..pi/2; neg flags a half-turn to undo on the result.
  function automatic norm_t normalize(input logic signed [ANGLE_W-1:0] th);
    logic signed [ANGLE_W-1:0] t;
    norm_t r;
    t = th > PI_Q14 ? th - TWO_PI_Q14 : th < -PI_Q14 ? th + TWO_PI_Q14 : th;
    r.neg = t > HALF_PI_Q14 || t < -HALF_PI_Q14;
    r.z = t > HALF_PI_Q14 ? t - PI_Q14 : t < -HALF_PI_Q14 ? t + PI_Q14 : t;
    return r;
  endfunction
endpackage

// File: rtl/fifo.sv
// fifo: show-ahead synchronous FIFO with full/empty flags; a read while full frees room for a same-cycle write.
module fifo #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr_ok, rd_ok;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= din;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
endmodule

// File: rtl/cordic_top.sv
// cordic_top: streaming Q14 CORDIC sin/cos engine between an input angle FIFO and a show-ahead result FIFO.
module cordic_top
  import cordic_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ITER = CORDIC_ITER
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_wr_en,
  input  logic [ANGLE_W-1:0]  theta_in,
  output logic                in_full,
  input  logic                out_rd_en,
  output logic                out_empty,
  output logic [DATA_W-1:0]   cos_dout,
  output logic [DATA_W-1:0]   sin_dout
);
  logic [ANGLE_W-1:0] in_dout;
  logic in_empty, out_full, en;
  logic [2*DATA_W-1:0] out_dout;
  logic v [0:ITER];
  logic ng [0:ITER];
  logic signed [DATA_W-1:0] xs [0:ITER];
  logic signed [DATA_W-1:0] ys [0:ITER];
  logic signed [ANGLE_W-1:0] zs [0:ITER];
  logic signed [DATA_W-1:0] cos_o, sin_o;
  norm_t nz;
  // The whole pipeline freezes while the output FIFO cannot take a result.
  assign en = !out_full;
  assign nz = normalize($signed(in_dout));
  fifo #(.W(ANGLE_W), .DEPTH(FIFO_DEPTH)) u_in (
    .clk(clk), .reset(reset), .wr_en(in_wr_en), .din(theta_in),
    .rd_en(!in_empty && en), .dout(in_dout), .full(in_full), .empty(in_empty)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v[0] <= 1'b0;
      ng[0] <= 1'b0;
      xs[0] <= '0;
      ys[0] <= '0;
      zs[0] <= '0;
    end else if (en) begin
      v[0] <= !in_empty;
      ng[0] <= nz.neg;
      xs[0] <= DATA_W'(K_Q14);
      ys[0] <= '0;
      zs[0] <= $signed(nz.z);
    end
  end
  for (genvar i = 0; i < ITER; i++) begin : g_stage
    logic dn;
    assign dn = zs[i][ANGLE_W-1];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v[i+1] <= 1'b0;
        ng[i+1] <= 1'b0;
        xs[i+1] <= '0;
        ys[i+1] <= '0;
        zs[i+1] <= '0;
      end else if (en) begin
        v[i+1] <= v[i];
        ng[i+1] <= ng[i];
        xs[i+1] <= dn ? xs[i] + (ys[i] >>> i) : xs[i] - (ys[i] >>> i);
        ys[i+1] <= dn ? ys[i] - (xs[i] >>> i) : ys[i] + (xs[i] >>> i);
        zs[i+1] <= dn ? zs[i] + ATAN_Q14[i] : zs[i] - ATAN_Q14[i];
      end
    end
  end
  assign cos_o = ng[ITER] ? -xs[ITER] : xs[ITER];
  assign sin_o = ng[ITER] ? -ys[ITER] : ys[ITER];
  fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_out (
    .clk(clk), .reset(reset), .wr_en(v[ITER] && en), .din({cos_o, sin_o}),
    .rd_en(out_rd_en), .dout(out_dout), .full(out_full), .empty(out_empty)
  );
  assign cos_dout = out_dout[2*DATA_W-1:DATA_W];
  assign sin_dout = out_dout[DATA_W-1:0];
endmodule

// File: tb/tb_cordic_top.sv
// tb_cordic_top: directed vector table plus sweep, backpressure and reset sequences for cordic_top.
module tb_cordic_top;
  localparam int PI = 51471, HALF = 25735, TWO_PI = 102943, K = 9949;
  localparam int DEPTH = 16, NIT = 16;
  logic clk = 0, reset = 1, in_wr_en = 0, out_rd_en = 0;
  logic [31:0] theta_in = 0;
  logic in_full, out_empty;
  logic [15:0] cos_dout, sin_dout;
  int checks = 0, failures = 0;
  int atan_t [16] = '{12867, 7596, 4013, 2037, 1022, 511, 255, 127, 63, 31, 15, 7, 3, 1, 0, 0};
  typedef struct {int theta; int clo; int chi; int slo; int shi;} vec_t;
  vec_t vt [4];
  logic [31:0] exp_q [$];
  int sweep_th [721];

  cordic_top dut (.clk(clk), .reset(reset), .in_wr_en(in_wr_en), .theta_in(theta_in),
                  .in_full(in_full), .out_rd_en(out_rd_en), .out_empty(out_empty),
                  .cos_dout(cos_dout), .sin_dout(sin_dout));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int th);
    int t, z;
    bit n;
    shortint x, y, nx;
    t = th;
    if (t > PI) t -= TWO_PI; else if (t < -PI) t += TWO_PI;
    n = 0;
    if (t > HALF) begin t -= PI; n = 1; end else if (t < -HALF) begin t += PI; n = 1; end
    x = shortint'(K); y = 0; z = t;
    for (int i = 0; i < 16; i++) begin
      if (z >= 0) begin nx = x - (y >>> i); y = y + (x >>> i); z -= atan_t[i]; end
      else begin nx = x + (y >>> i); y = y - (x >>> i); z += atan_t[i]; end
      x = nx;
    end
    if (n) begin x = -x; y = -y; end
    return {x, y};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reads whatever is at the head on each negedge until n results are seen or the budget expires.
  task automatic drain(input string name, input int n, input int budget);
    int got = 0, cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!out_empty) begin
        chk(name, {cos_dout, sin_dout}, exp_q.pop_front());
        got++;
        out_rd_en = 1;
      end else out_rd_en = 0;
    end
    @(negedge clk);
    out_rd_en = 0;
    chk_rng({name, "_count"}, got, n, n);
  endtask

  initial begin
    int n, acc;
    vt[0] = '{0, 16'h3FFE, 16'h4001, -2, 2};
    vt[1] = '{HALF, -3, 3, 16'h4000 - 3, 16'h4000 + 3};
    vt[2] = '{-PI, -16'h4000 - 3, -16'h4000 + 3, -3, 3};
    vt[3] = '{TWO_PI, 16'h4000 - 3, 16'h4000 + 3, -3, 3};
    repeat (3) @(negedge clk);
    chk("rst_in_full", {31'b0, in_full}, 0);
    chk("rst_out_empty", {31'b0, out_empty}, 1);
    chk("rst_cos", {16'b0, cos_dout}, 0);
    chk("rst_sin", {16'b0, sin_dout}, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    chk("idle_out_empty", {31'b0, out_empty}, 1);

    for (int v = 0; v < 4; v++) begin
      in_wr_en = 1; theta_in = vt[v].theta;
      @(negedge clk);
      in_wr_en = 0;
      n = 0;
      while (out_empty && n < 40) begin @(negedge clk); n++; end
      chk_rng($sformatf("latency_%0d", v), n, 1, NIT + 4);
      chk_rng($sformatf("cos_%0d", v), int'($signed(cos_dout)), vt[v].clo, vt[v].chi);
      chk_rng($sformatf("sin_%0d", v), int'($signed(sin_dout)), vt[v].slo, vt[v].shi);
      chk($sformatf("exact_%0d", v), {cos_dout, sin_dout}, model(vt[v].theta));
      out_rd_en = 1;
      @(negedge clk);
      out_rd_en = 0;
      chk($sformatf("popped_%0d", v), {31'b0, out_empty}, 1);
    end

    for (int d = -360; d <= 360; d++) begin
      sweep_th[d + 360] = int'(real'(d) * 3.14159265358979 / 180.0 * 16384.0);
      exp_q.push_back(model(sweep_th[d + 360]));
    end
    fork
      begin
        int wi = 0;
        while (wi < 721) begin
          @(negedge clk);
          if (!in_full) begin in_wr_en = 1; theta_in = sweep_th[wi]; wi++; end
          else in_wr_en = 0;
        end
        @(negedge clk);
        in_wr_en = 0;
      end
      drain("sweep", 721, 3000);
    join

    acc = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      in_wr_en = 1; theta_in = k * 1000 - 40000;
      if (!in_full) begin exp_q.push_back(model(k * 1000 - 40000)); acc++; end
    end
    @(negedge clk);
    in_wr_en = 0;
    chk("bp_in_full", {31'b0, in_full}, 1);
    chk_rng("bp_accepted", acc, 2 * DEPTH + NIT + 1, 2 * DEPTH + NIT + 1);
    drain("bp_drain", acc, 500);
    chk("bp_in_full_after", {31'b0, in_full}, 0);
    chk_rng("bp_queue_left", exp_q.size(), 0, 0);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_wr_en = 1; theta_in = k * 5000;
    end
    @(negedge clk);
    in_wr_en = 0;
    repeat (8) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    n = 0;
    repeat (NIT + 8) begin @(negedge clk); if (!out_empty) n++; end
    chk_rng("midrst_discard", n, 0, 0);
    chk("midrst_in_full", {31'b0, in_full}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
